instr_fetch_unit: RTL and testbench

- Instruction-side initiator for the combinational Harvard instruction memory; owns the program counter and drives the word address.
- Captures the big-endian 32-bit word returned in the same cycle and presents it with its PC to decode through a valid/ready output register.
- Handles MIPS-style redirects with one branch delay slot, and a halt on a jump to HALT_ADDR.

---
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory and registers word+PC toward decode.
// Optional misaligned-redirect fault under macro FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        halted,
    output logic        fetch_fault
);
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] target_pc;
    logic        advance, accept, take_redirect, bad_target, to_drain;

    assign instr_address = pc;
    assign accept        = out_valid && out_ready;
    // A redirect is only meaningful when the jump itself leaves the output register.
    assign take_redirect = advance && accept && redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    assign bad_target = (redirect_target[1:0] != 2'b00);
    assign target_pc  = redirect_target;
`else
    assign bad_target = 1'b0;
    assign target_pc  = {redirect_target[31:2], 2'b00};
`endif

    assign to_drain = take_redirect && (bad_target || (redirect_target == HALT_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (to_drain) state_nxt = S_DRAIN;
            S_DRAIN: if (accept)   state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        advance = (state == S_RUN) && (!out_valid || out_ready);
        halted  = (state == S_HALT);
    end

    // The delay slot is captured by the same advance that consumes the jump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_pc    <= 32'h0;
        end else if (advance) begin
            out_instr <= instr_readdata;
            out_pc    <= pc;
            out_valid <= 1'b1;
            if (take_redirect) begin
                if (!bad_target) pc <= target_pc;
            end else begin
                pc <= pc + 32'd4;
            end
        end else if ((state == S_DRAIN) && accept) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           fetch_fault <= 1'b0;
        else if (take_redirect && bad_target) fetch_fault <= 1'b1;
    end
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a stream-level model.
module tb_instr_fetch_unit;
    localparam logic [31:0] HALT = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        halted;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .instr_address(instr_address), .instr_readdata(instr_readdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halted(halted), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0020_0008;
        else if (a == 32'h4) return 32'h0;
        else                 return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign instr_readdata = memword(instr_address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        start_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", out_instr); end
        checks++; if (halted !== 1'b0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_flags got %0b%0b want 00", halted, fetch_fault); end
        checks++; if (instr_address !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", instr_address); end
        release_reset();
        tick();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0020_0008 || out_pc !== 32'h0) begin
            errors++; $display("FAIL first_fetch got v=%0b i=%h pc=%h want 1 00200008 0", out_valid, out_instr, out_pc); end
        tick();
        checks++; if (out_pc !== 32'h4 || instr_address !== 32'h8) begin
            errors++; $display("FAIL second_fetch got pc=%h addr=%h want 4 8", out_pc, instr_address); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        start_reset();
        release_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0020_0008 || instr_address !== 32'h4) begin
                errors++; $display("FAIL stall_hold got v=%0b pc=%h i=%h addr=%h want 1 0 00200008 4", out_valid, out_pc, out_instr, instr_address); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h4 || out_instr !== 32'h0) begin errors++; $display("FAIL stall_resume got pc=%h i=%h want 4 0", out_pc, out_instr); end
        tick();
        checks++; if (out_pc !== 32'h8 || out_instr !== memword(32'h8)) begin errors++; $display("FAIL stall_next got pc=%h want 8", out_pc); end
    endtask

    task automatic test_redirect();
        out_ready = 1'b1;
        start_reset();
        release_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL delay_slot got pc=%h want 4", out_pc); end
        tick();
        checks++; if (out_pc !== 32'h40 || out_instr !== memword(32'h40)) begin errors++; $display("FAIL target got pc=%h i=%h want 40", out_pc, out_instr); end
        tick();
        checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL target_next got pc=%h want 44", out_pc); end
    endtask

    // Brings the unit to DRAIN with the delay slot (pc 12) in the output register, out_ready low.
    task automatic reach_drain();
        out_ready = 1'b1;
        start_reset();
        release_reset();
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_target = HALT;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        reach_drain();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd12 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_slot got v=%0b pc=%h h=%0b want 1 c 0", out_valid, out_pc, halted); end
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd12 || instr_address !== HALT) begin
            errors++; $display("FAIL drain_hold got v=%0b pc=%h addr=%h want 1 c 0", out_valid, out_pc, instr_address); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halted got v=%0b h=%0b want 0 1", out_valid, halted); end
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        tick(); tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || instr_address !== HALT) begin
            errors++; $display("FAIL halt_sticky got v=%0b h=%0b addr=%h want 0 1 0", out_valid, halted, instr_address); end
    endtask

    task automatic test_reset_mid_drain();
        reach_drain();
        start_reset();
        checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || instr_address !== 32'h0) begin
            errors++; $display("FAIL drain_reset got v=%0b h=%0b addr=%h want 0 0 0", out_valid, halted, instr_address); end
        out_ready = 1'b1;
        release_reset();
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL restart got v=%0b pc=%h want 1 0", out_valid, out_pc); end
    endtask

    task automatic test_align();
        out_ready = 1'b1;
        start_reset();
        release_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h42;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_pc !== 32'h4 || out_valid !== 1'b1) begin errors++; $display("FAIL align_slot got pc=%h want 4", out_pc); end
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (fetch_fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL align_fault got f=%0b h=%0b v=%0b want 1 1 0", fetch_fault, halted, out_valid); end
`else
        checks++; if (out_pc !== 32'h40 || fetch_fault !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL align_mask got pc=%h f=%0b h=%0b want 40 0 0", out_pc, fetch_fault, halted); end
`endif
    endtask

    // Model tracks the delivered instruction stream: next fetch address, pending halt, sticky fault.
    task automatic test_random();
        logic        m_valid, m_fault, bad, acc, rdy, rv;
        logic [31:0] m_pc, m_instr, m_fetch, tgt;
        int          m_mode, r;
        start_reset();
        release_reset();
        m_valid = 0; m_fault = 0; m_pc = 0; m_instr = 0; m_fetch = 32'h0; m_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                start_reset();
                release_reset();
                m_valid = 0; m_fault = 0; m_pc = 0; m_instr = 0; m_fetch = 32'h0; m_mode = 0;
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 3) == 0);
            r   = $urandom_range(0, 39);
            tgt = (r == 0) ? HALT : ((($urandom & 32'h0000_0ffc) | 32'h100) | ((r < 4) ? 32'(r) : 32'h0));
            out_ready = rdy; redirect_valid = rv; redirect_target = tgt;
            acc = m_valid && rdy;
            if (m_mode == 0) begin
                if (!m_valid || rdy) begin
                    m_pc = m_fetch; m_instr = memword(m_fetch); m_valid = 1;
                    if (acc && rv) begin
                        bad = ALIGN && (tgt[1:0] != 2'b00);
                        if (bad) begin m_fault = 1; m_mode = 1; end
                        else if (tgt == HALT) begin m_fetch = tgt; m_mode = 1; end
                        else m_fetch = tgt & 32'hffff_fffc;
                    end else begin
                        m_fetch = m_fetch + 32'd4;
                    end
                end
            end else if (m_mode == 1 && acc) begin
                m_valid = 0; m_mode = 2;
            end
            tick();
            checks++; if (out_valid !== m_valid || halted !== (m_mode == 2) || fetch_fault !== m_fault) begin
                errors++; $display("FAIL rand_ctl c=%0d got v=%0b h=%0b f=%0b want %0b %0b %0b", c, out_valid, halted, fetch_fault, m_valid, m_mode == 2, m_fault); end
            if (m_valid) begin
                checks++; if (out_pc !== m_pc || out_instr !== m_instr) begin
                    errors++; $display("FAIL rand_data c=%0d got pc=%h i=%h want %h %h", c, out_pc, out_instr, m_pc, m_instr); end
            end
            if (m_mode == 0) begin
                checks++; if (instr_address !== m_fetch) begin
                    errors++; $display("FAIL rand_addr c=%0d got %h want %h", c, instr_address, m_fetch); end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_reset_mid_drain();
        test_align();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
